// File: rtl/dnn_result_reader.sv
// Walks the engine's ten class scores after `done` and hands the argmax (digit, score) downstream.
// Optional runner-up tracking and `margin` output are enabled with DNN_READER_MARGIN_EN.
module dnn_result_reader #(
    parameter int DATA_WIDTH  = 10,
    parameter int NUM_CLASSES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         eng_done,
    output logic [3:0]                   out_idx,
    input  logic signed [DATA_WIDTH-1:0] score,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [3:0]                   digit,
    output logic signed [DATA_WIDTH-1:0] max_score,
    output logic [1:0]                   state_dbg
`ifdef DNN_READER_MARGIN_EN
    ,
    output logic signed [DATA_WIDTH:0]   margin
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] REARM = 2'd3;

    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    // Handshake: result_valid is raised on HOLD entry and held, with digit/max_score/margin
    // frozen, until a cycle where result_valid & result_ready are both high; it drops on that edge.

    logic [1:0] state;
    logic       beats;
    logic       last_sample;

    assign state_dbg   = state;
    assign beats       = score > max_score;
    assign last_sample = out_idx == LAST_IDX;

`ifdef DNN_READER_MARGIN_EN
    logic signed [DATA_WIDTH-1:0] runner_up;
    logic signed [DATA_WIDTH-1:0] nxt_max;
    logic signed [DATA_WIDTH-1:0] nxt_runner;
    logic signed [DATA_WIDTH:0]   nxt_margin;

    // A new max demotes the old one; a tie with the max also becomes runner-up.
    always_comb begin
        nxt_max    = max_score;
        nxt_runner = runner_up;
        if (beats) begin
            nxt_max    = score;
            nxt_runner = max_score;
        end else if (score == max_score || score > runner_up) begin
            nxt_runner = score;
        end
        nxt_margin = {nxt_max[DATA_WIDTH-1], nxt_max} - {nxt_runner[DATA_WIDTH-1], nxt_runner};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            out_idx      <= 4'd0;
            result_valid <= 1'b0;
            digit        <= 4'd0;
            max_score    <= '0;
`ifdef DNN_READER_MARGIN_EN
            runner_up    <= '0;
            margin       <= '0;
`endif
        end else if (clear) begin
            state        <= IDLE;
            out_idx      <= 4'd0;
            result_valid <= 1'b0;
            digit        <= 4'd0;
            max_score    <= '0;
`ifdef DNN_READER_MARGIN_EN
            runner_up    <= '0;
            margin       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    out_idx <= 4'd0;
                    if (eng_done) begin
                        state     <= SCAN;
                        max_score <= MOST_NEG;
                        digit     <= 4'd0;
`ifdef DNN_READER_MARGIN_EN
                        runner_up <= MOST_NEG;
`endif
                    end
                end
                SCAN: begin
                    if (!eng_done) begin
                        // Engine restarted mid-scan: discard the partial reduction.
                        state   <= IDLE;
                        out_idx <= 4'd0;
                    end else begin
                        if (beats) begin
                            max_score <= score;
                            digit     <= out_idx;
                        end
`ifdef DNN_READER_MARGIN_EN
                        runner_up <= nxt_runner;
`endif
                        if (last_sample) begin
                            state        <= HOLD;
                            result_valid <= 1'b1;
                            out_idx      <= 4'd0;
`ifdef DNN_READER_MARGIN_EN
                            margin       <= nxt_margin;
`endif
                        end else begin
                            out_idx <= out_idx + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        state        <= REARM;
                        result_valid <= 1'b0;
                    end
                end
                REARM: begin
                    if (!eng_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dnn_result_reader.md
# dnn_result_reader

Result-readout sequencer for the MNIST inference engine. When the engine raises `done`, the block walks the engine's indexed score port (`out_idx`/`out`) across the ten class scores and reduces them to a winning digit and score. It then presents the result downstream over a valid/ready handshake. It sits beside the engine top level, on the consumer side of its score-select port.

## Interface
- `DATA_WIDTH`, 10, signed score width; must match the engine output.
- `NUM_CLASSES`, 10, number of scores scanned; index width is fixed at 4 bits.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous abort; forces IDLE and drops any pending result.
- `eng_done`  in  1  engine done level.
- `out_idx`  out  4  score select driven to the engine; registered.
- `score`  in  DATA_WIDTH  signed score returned combinationally for `out_idx`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  downstream accepts the result.
- `digit`  out  4  winning class index.
- `max_score`  out  DATA_WIDTH  signed winning score.
- `margin`  out  DATA_WIDTH+1  winner minus runner-up; exists only with `DNN_READER_MARGIN_EN`.

## Operation
- States: IDLE, SCAN, HOLD, REARM.
- **IDLE:**
  - `out_idx` = 0.
  - When `eng_done`=1, go to SCAN.
  - On that entry, load `max_score` := most negative value, `digit` := 0, and the internal count k := 0.
- **SCAN:**
  - Each cycle, `out_idx` = k and `score` is sampled at the clock edge.
  - If `score` > `max_score` (signed, strict), update both `max_score` and `digit` := k.
  - Ties keep the lower index.
  - After sampling at k = NUM_CLASSES-1, go to HOLD.
- **HOLD:**
  - `result_valid` = 1.
  - `digit`, `max_score` and `margin` are stable until the handshake completes.
  - Go to REARM on `result_valid & result_ready`.
- **REARM:**
  - Wait for `eng_done`=0, then go to IDLE.
  - This guarantees exactly one result per `done` assertion.
- Abort conditions:
  - `eng_done` falling while in SCAN means the engine restarted. Return to IDLE and emit no result.
  - `eng_done` falling while in HOLD is ignored; the result is still delivered.
- `clear` has priority over all transitions and forces IDLE from any state.
- Comparisons are full-width signed. Values are never saturated or truncated.

## Timing
- Reset values:
  - state = IDLE, `out_idx` = 0, `result_valid` = 0, `digit` = 0.
  - `max_score` = 0.
  - `margin` = 0 when enabled.
- Latency:
  - `eng_done` is sampled high at edge E.
  - SCAN occupies cycles E+1..E+10, with `out_idx` = 0..9 respectively.
  - `result_valid` rises in cycle E+11.
- `result_valid` is registered. It falls on the edge after the handshake.
- With `result_ready` held at 1, `result_valid` is high for exactly one cycle.
- Back-to-back runs need `eng_done` to go low for at least one cycle. Minimum period is 13 cycles.
- Async `rst` assertion mid-SCAN or mid-HOLD immediately returns to reset values. Deassertion is synchronized by the instantiating top.

## Configuration
- `DNN_READER_MARGIN_EN` defined:
  - Adds a runner-up register, initialized to the most negative value and tracked during SCAN.
  - A score that beats the max demotes the old max to runner-up.
  - A score that ties the max becomes runner-up.
  - Adds the `margin` port, equal to `max_score` - runner-up, sign-extended to DATA_WIDTH+1 and registered at HOLD entry.
- Undefined: no runner-up logic and no `margin` port. All other behaviour is identical.

## Test plan
- Scores {3,-7,12,0,5,12,-1,4,2,9}, `result_ready`=1 → `digit`=2, `max_score`=12, `margin`=0, `result_valid` for 1 cycle at E+11.
- All scores -512 → `digit`=0, `max_score`=-512, `margin`=0.
- Scores {-5,-5,-5,-5,-5,-5,-5,-5,-5,511} with `result_ready` low for 6 cycles → HOLD keeps `digit`=9 and `max_score`=511 stable for 6 cycles, `margin`=516.
- `eng_done` dropped at `out_idx`=4 → `result_valid` never asserts, state returns to IDLE, and the next `done` gives a clean 10-cycle scan.
- `eng_done` held high after the handshake → no second result; lower it for 1 cycle and raise it again → a second result appears 11 cycles later.
- `rst` pulsed low mid-SCAN, and separately `clear` pulsed in HOLD → all outputs return to reset values, `out_idx`=0, no result emitted.
